segre_controller: RTL and testbench

Multi-cycle sequencing FSM for the Segre core, directly upstream of the IF stage. It generates `fsm_state_o`, which gates every stage. The IF stage uses it to drive `mem_rd_o` and advance the PC, and WB uses it to commit. Each instruction walks IF → ID → EX → (MEM) → WB. IF and MEM hold until the corresponding memory signals ready, under an optional watchdog that halts the core on a stuck access.

---
 rtl/segre_pkg.sv | 13 +
 rtl/segre_controller.sv | 102 ++++++++++
 tb/tb_segre_controller.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/segre_pkg.sv
// Shared Segre core types: the controller's state encoding.
package segre_pkg;

    typedef enum logic [2:0] {
        IF_STATE,
        ID_STATE,
        EX_STATE,
        MEM_STATE,
        WB_STATE,
        HALT_STATE
    } fsm_state_e;

endpackage

// File: rtl/segre_controller.sv
// Multi-cycle IF/ID/EX/MEM/WB sequencer with a memory-stall watchdog.
// Optional perf counters enabled by defining SEGRE_CTRL_PERF_CNT_EN.
module segre_controller #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk_i,
    input  logic        rsn_i,
    input  logic        imem_ready_i,
    input  logic        dmem_ready_i,
    input  logic        mem_access_i,
    input  logic        halt_i,
    output logic [2:0]  fsm_state_o,
    output logic        instr_retired_o,
    output logic        halted_o,
    output logic        mem_timeout_o,
    output logic [63:0] cycle_cnt_o,
    output logic [63:0] instret_cnt_o
);
    import segre_pkg::*;

    // Keep the counter at least 1 bit wide when the watchdog is disabled.
    localparam int unsigned WaitW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [WaitW-1:0] WaitLast = WaitW'(TIMEOUT_CYCLES - 1);

    fsm_state_e       r_state;
    fsm_state_e       w_state_next;
    logic [WaitW-1:0] r_wait_cnt;
    logic [WaitW-1:0] w_wait_cnt_next;
    logic             r_timeout;
    logic             w_timeout_next;
    logic             w_waiting;
    logic             w_expire;

    always_comb begin
        w_state_next   = r_state;
        w_timeout_next = r_timeout;
        w_waiting      = ((r_state == IF_STATE) && !imem_ready_i) ||
                         ((r_state == MEM_STATE) && !dmem_ready_i);
        w_expire       = (TIMEOUT_CYCLES != 0) && w_waiting && (r_wait_cnt == WaitLast);

        case (r_state)
            IF_STATE:  if (imem_ready_i) w_state_next = ID_STATE;
            ID_STATE:  w_state_next = EX_STATE;
            EX_STATE:  w_state_next = mem_access_i ? MEM_STATE : WB_STATE;
            MEM_STATE: if (dmem_ready_i) w_state_next = WB_STATE;
            WB_STATE:  w_state_next = halt_i ? HALT_STATE : IF_STATE;
            default:   w_state_next = HALT_STATE;
        endcase

        if (w_expire) begin
            w_state_next   = HALT_STATE;
            w_timeout_next = 1'b1;
        end

        if ((TIMEOUT_CYCLES == 0) || (w_state_next != r_state)) begin
            w_wait_cnt_next = '0;
        end else if (w_waiting) begin
            w_wait_cnt_next = r_wait_cnt + WaitW'(1);
        end else begin
            w_wait_cnt_next = r_wait_cnt;
        end
    end

    always_ff @(posedge clk_i or negedge rsn_i) begin
        if (!rsn_i) begin
            r_state    <= IF_STATE;
            r_wait_cnt <= '0;
            r_timeout  <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_wait_cnt <= w_wait_cnt_next;
            r_timeout  <= w_timeout_next;
        end
    end

    assign fsm_state_o     = r_state;
    assign instr_retired_o = (r_state == WB_STATE);
    assign halted_o        = (r_state == HALT_STATE);
    assign mem_timeout_o   = r_timeout;

`ifdef SEGRE_CTRL_PERF_CNT_EN
    logic [63:0] r_cycle_cnt;
    logic [63:0] r_instret_cnt;

    always_ff @(posedge clk_i or negedge rsn_i) begin
        if (!rsn_i) begin
            r_cycle_cnt   <= '0;
            r_instret_cnt <= '0;
        end else begin
            if (r_state != HALT_STATE) r_cycle_cnt <= r_cycle_cnt + 64'd1;
            if (r_state == WB_STATE) r_instret_cnt <= r_instret_cnt + 64'd1;
        end
    end

    assign cycle_cnt_o   = r_cycle_cnt;
    assign instret_cnt_o = r_instret_cnt;
`else
    assign cycle_cnt_o   = '0;
    assign instret_cnt_o = '0;
`endif

endmodule

// File: tb/tb_segre_controller.sv
// Scoreboard bench for segre_controller: expected states queued per scenario, popped per cycle.
module tb_segre_controller;
    import segre_pkg::*;

`ifdef SEGRE_CTRL_PERF_CNT_EN
    localparam bit PerfEn = 1'b1;
`else
    localparam bit PerfEn = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rsn;
    logic        imem_ready;
    logic        dmem_ready;
    logic        mem_access;
    logic        halt;
    logic [2:0]  fsm_state;
    logic        instr_retired;
    logic        halted;
    logic        mem_timeout;
    logic [63:0] cycle_cnt;
    logic [63:0] instret_cnt;

    int checks = 0;
    int errors = 0;

    fsm_state_e exp_state_q[$];
    logic       exp_ret_q[$];

    always #5 clk = ~clk;

    segre_controller #(.TIMEOUT_CYCLES(4)) dut (
        .clk_i          (clk),
        .rsn_i          (rsn),
        .imem_ready_i   (imem_ready),
        .dmem_ready_i   (dmem_ready),
        .mem_access_i   (mem_access),
        .halt_i         (halt),
        .fsm_state_o    (fsm_state),
        .instr_retired_o(instr_retired),
        .halted_o       (halted),
        .mem_timeout_o  (mem_timeout),
        .cycle_cnt_o    (cycle_cnt),
        .instret_cnt_o  (instret_cnt)
    );

    task automatic apply_reset();
        rsn        = 1'b0;
        imem_ready = 1'b0;
        dmem_ready = 1'b0;
        mem_access = 1'b0;
        halt       = 1'b0;
        repeat (2) @(negedge clk);
        rsn = 1'b1;
    endtask

    task automatic test_reset();
        rsn        = 1'b0;
        imem_ready = 1'b1;
        dmem_ready = 1'b1;
        mem_access = 1'b1;
        halt       = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (fsm_state !== IF_STATE) begin errors++;
            $display("FAIL reset_state got %0d want %0d", fsm_state, IF_STATE); end
        checks++; if (instr_retired !== 1'b0) begin errors++;
            $display("FAIL reset_retired got %b want 0", instr_retired); end
        checks++; if (halted !== 1'b0) begin errors++;
            $display("FAIL reset_halted got %b want 0", halted); end
        checks++; if (mem_timeout !== 1'b0) begin errors++;
            $display("FAIL reset_timeout got %b want 0", mem_timeout); end
        checks++; if (cycle_cnt !== 64'd0) begin errors++;
            $display("FAIL reset_cycle_cnt got %0d want 0", cycle_cnt); end
        checks++; if (instret_cnt !== 64'd0) begin errors++;
            $display("FAIL reset_instret_cnt got %0d want 0", instret_cnt); end
        rsn = 1'b1;
    endtask

    task automatic test_no_mem();
        fsm_state_e seq[4] = '{IF_STATE, ID_STATE, EX_STATE, WB_STATE};
        fsm_state_e st;
        logic       ret;
        apply_reset();
        imem_ready = 1'b1;
        for (int k = 0; k < 40; k++) begin
            exp_state_q.push_back(seq[k % 4]);
            exp_ret_q.push_back((k % 4) == 3);
        end
        for (int k = 0; k < 40; k++) begin
            st  = exp_state_q.pop_front();
            ret = exp_ret_q.pop_front();
            checks++; if (fsm_state !== st) begin errors++;
                $display("FAIL no_mem_state k=%0d got %0d want %0d", k, fsm_state, st); end
            checks++; if (instr_retired !== ret) begin errors++;
                $display("FAIL no_mem_retired k=%0d got %b want %b", k, instr_retired, ret); end
            checks++; if (cycle_cnt !== (PerfEn ? 64'(k) : 64'd0)) begin errors++;
                $display("FAIL no_mem_cycle_cnt k=%0d got %0d", k, cycle_cnt); end
            checks++; if (instret_cnt !== (PerfEn ? 64'(k / 4) : 64'd0)) begin errors++;
                $display("FAIL no_mem_instret_cnt k=%0d got %0d", k, instret_cnt); end
            @(negedge clk);
        end
        checks++; if (cycle_cnt !== (PerfEn ? 64'd40 : 64'd0)) begin errors++;
            $display("FAIL no_mem_cycle_40 got %0d want %0d", cycle_cnt, PerfEn ? 40 : 0); end
        checks++; if (instret_cnt !== (PerfEn ? 64'd10 : 64'd0)) begin errors++;
            $display("FAIL no_mem_instret_10 got %0d want %0d", instret_cnt, PerfEn ? 10 : 0); end
    endtask

    task automatic test_slow_load();
        fsm_state_e seq[9] = '{IF_STATE, ID_STATE, EX_STATE, MEM_STATE, MEM_STATE,
                               MEM_STATE, MEM_STATE, WB_STATE, IF_STATE};
        fsm_state_e st;
        logic       ret;
        apply_reset();
        imem_ready = 1'b1;
        mem_access = 1'b1;
        for (int k = 0; k < 9; k++) begin
            exp_state_q.push_back(seq[k]);
            exp_ret_q.push_back(k == 7);
        end
        for (int k = 0; k < 9; k++) begin
            st  = exp_state_q.pop_front();
            ret = exp_ret_q.pop_front();
            checks++; if (fsm_state !== st) begin errors++;
                $display("FAIL load_state k=%0d got %0d want %0d", k, fsm_state, st); end
            checks++; if (instr_retired !== ret) begin errors++;
                $display("FAIL load_retired k=%0d got %b want %b", k, instr_retired, ret); end
            dmem_ready = (k == 6);
            @(negedge clk);
        end
        checks++; if (mem_timeout !== 1'b0) begin errors++;
            $display("FAIL load_timeout got %b want 0", mem_timeout); end
        checks++; if (instret_cnt !== (PerfEn ? 64'd1 : 64'd0)) begin errors++;
            $display("FAIL load_instret got %0d", instret_cnt); end
    endtask

    task automatic test_if_watchdog();
        fsm_state_e seq[6] = '{IF_STATE, IF_STATE, IF_STATE, IF_STATE, ID_STATE, EX_STATE};
        fsm_state_e st;
        apply_reset();
        for (int k = 0; k < 25; k++) exp_state_q.push_back(k < 4 ? IF_STATE : HALT_STATE);
        for (int k = 0; k < 25; k++) begin
            st = exp_state_q.pop_front();
            checks++; if (fsm_state !== st) begin errors++;
                $display("FAIL if_wdog_state k=%0d got %0d want %0d", k, fsm_state, st); end
            checks++; if (mem_timeout !== (k >= 4)) begin errors++;
                $display("FAIL if_wdog_timeout k=%0d got %b", k, mem_timeout); end
            checks++; if (halted !== (k >= 4)) begin errors++;
                $display("FAIL if_wdog_halted k=%0d got %b", k, halted); end
            if (k >= 4) begin
                imem_ready = 1'($urandom);
                dmem_ready = 1'($urandom);
                mem_access = 1'($urandom);
                halt       = 1'($urandom);
            end
            @(negedge clk);
        end
        checks++; if (cycle_cnt !== (PerfEn ? 64'd4 : 64'd0)) begin errors++;
            $display("FAIL if_wdog_cycle_frozen got %0d", cycle_cnt); end

        apply_reset();
        for (int k = 0; k < 6; k++) exp_state_q.push_back(seq[k]);
        for (int k = 0; k < 6; k++) begin
            st = exp_state_q.pop_front();
            checks++; if (fsm_state !== st) begin errors++;
                $display("FAIL if_ready_late_state k=%0d got %0d want %0d", k, fsm_state, st); end
            checks++; if (mem_timeout !== 1'b0) begin errors++;
                $display("FAIL if_ready_late_timeout k=%0d got %b want 0", k, mem_timeout); end
            imem_ready = (k == 3);
            @(negedge clk);
        end
    endtask

    task automatic test_mem_watchdog();
        fsm_state_e seq[9] = '{IF_STATE, ID_STATE, EX_STATE, MEM_STATE, MEM_STATE,
                               MEM_STATE, MEM_STATE, HALT_STATE, HALT_STATE};
        fsm_state_e st;
        apply_reset();
        imem_ready = 1'b1;
        mem_access = 1'b1;
        for (int k = 0; k < 9; k++) exp_state_q.push_back(seq[k]);
        for (int k = 0; k < 9; k++) begin
            st = exp_state_q.pop_front();
            checks++; if (fsm_state !== st) begin errors++;
                $display("FAIL mem_wdog_state k=%0d got %0d want %0d", k, fsm_state, st); end
            checks++; if (mem_timeout !== (k >= 7)) begin errors++;
                $display("FAIL mem_wdog_timeout k=%0d got %b", k, mem_timeout); end
            @(negedge clk);
        end
    endtask

    task automatic test_halt();
        fsm_state_e st;
        logic       ret;
        apply_reset();
        imem_ready = 1'b1;
        halt       = 1'b1;
        exp_state_q.push_back(IF_STATE);
        exp_state_q.push_back(ID_STATE);
        exp_state_q.push_back(EX_STATE);
        exp_state_q.push_back(WB_STATE);
        for (int k = 0; k < 5; k++) exp_state_q.push_back(HALT_STATE);
        for (int k = 0; k < 9; k++) exp_ret_q.push_back(k == 3);
        for (int k = 0; k < 9; k++) begin
            st  = exp_state_q.pop_front();
            ret = exp_ret_q.pop_front();
            checks++; if (fsm_state !== st) begin errors++;
                $display("FAIL halt_state k=%0d got %0d want %0d", k, fsm_state, st); end
            checks++; if (instr_retired !== ret) begin errors++;
                $display("FAIL halt_retired k=%0d got %b want %b", k, instr_retired, ret); end
            checks++; if (halted !== (k >= 4)) begin errors++;
                $display("FAIL halt_halted k=%0d got %b", k, halted); end
            @(negedge clk);
        end
        checks++; if (instret_cnt !== (PerfEn ? 64'd1 : 64'd0)) begin errors++;
            $display("FAIL halt_instret_frozen got %0d", instret_cnt); end
        checks++; if (mem_timeout !== 1'b0) begin errors++;
            $display("FAIL halt_timeout got %b want 0", mem_timeout); end
    endtask

    task automatic test_reset_mid_mem();
        fsm_state_e seq[6] = '{IF_STATE, ID_STATE, EX_STATE, MEM_STATE, WB_STATE, IF_STATE};
        fsm_state_e st;
        apply_reset();
        imem_ready = 1'b1;
        mem_access = 1'b1;
        repeat (5) @(negedge clk);
        checks++; if (fsm_state !== MEM_STATE) begin errors++;
            $display("FAIL rst_mem_pre got %0d want %0d", fsm_state, MEM_STATE); end
        #2 rsn = 1'b0;
        #1;
        checks++; if (fsm_state !== IF_STATE) begin errors++;
            $display("FAIL rst_mem_async_state got %0d want %0d", fsm_state, IF_STATE); end
        checks++; if (cycle_cnt !== 64'd0 || instret_cnt !== 64'd0) begin errors++;
            $display("FAIL rst_mem_counters got %0d/%0d want 0/0", cycle_cnt, instret_cnt); end
        checks++; if (mem_timeout !== 1'b0) begin errors++;
            $display("FAIL rst_mem_timeout got %b want 0", mem_timeout); end
        @(negedge clk);
        rsn = 1'b1;
        for (int k = 0; k < 6; k++) exp_state_q.push_back(seq[k]);
        for (int k = 0; k < 6; k++) begin
            st = exp_state_q.pop_front();
            checks++; if (fsm_state !== st) begin errors++;
                $display("FAIL rst_mem_resume k=%0d got %0d want %0d", k, fsm_state, st); end
            dmem_ready = (k == 3);
            @(negedge clk);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout got no finish want finish");
        $fatal(1, "bench time limit");
    end

    initial begin
        rsn        = 1'b0;
        imem_ready = 1'b0;
        dmem_ready = 1'b0;
        mem_access = 1'b0;
        halt       = 1'b0;
        @(negedge clk);
        test_reset();
        test_no_mem();
        test_slow_load();
        test_if_watchdog();
        test_mem_watchdog();
        test_halt();
        test_reset_mid_mem();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
